difftest_commit_queue: RTL and testbench

Parametrised commit buffer between a multi-issue core's retire stage and the difftest commit/trap ports. Accepts up to IN_LANES in-order commits per cycle, buffers them, and emits exactly one registered commit per cycle toward DifftestInstrCommit (index 0). It also detects the trap instruction, latches the trap code, and maintains the cycle and instruction counters for DifftestTrapEvent, replacing the single-lane negedge capture logic in the top level.

---
 rtl/difftest_pkg.sv | 26 ++
 rtl/difftest_commit_queue_fifo.sv | 74 +++++++
 rtl/difftest_commit_queue.sv | 166 ++++++++++++++++
 tb/tb_difftest_commit_queue.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit path.
package difftest_pkg;

    // Opcode of the "good trap" instruction that ends a difftest run.
    localparam logic [6:0]  TRAP_OPCODE = 7'h6b;
    // Reset vector of the core; kept here so all difftest blocks agree on it.
    localparam logic [63:0] PC_START    = 64'h8000_0000;

    // One retired instruction as seen by difftest. Fields are sized for the
    // widest supported XLEN; narrower cores zero-extend into them.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic [63:0] a0;
    } commit_entry_t;

    // True when the instruction word carries the trap opcode.
    function automatic logic is_trap_inst(input logic [31:0] inst,
                                          input logic [6:0]  opcode);
        return inst[6:0] == opcode;
    endfunction

endpackage

// File: rtl/difftest_commit_queue_fifo.sv
// Multi-write, single-read circular buffer. Up to LANES entries are written
// per cycle at consecutive slots starting at the write pointer; one entry is
// read per cycle from the head. The head is exposed combinationally so the
// consumer can register it directly into its own output stage.
module commit_fifo_mw
    import difftest_pkg::*;
#(
    parameter  int LANES = 2,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [LANES-1:0]                wr_mask,
    input  commit_entry_t [LANES-1:0]       wr_data,
    input  logic                            rd_en,
    output commit_entry_t                   rd_data,
    output logic [CW-1:0]                   count
);

    commit_entry_t mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] push_n;
    logic [AW-1:0] lane_addr [LANES];

    // Lane i lands at wr_ptr+i; the pointer width makes the wrap implicit.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_addr
        assign lane_addr[gi] = wr_ptr_q + AW'(gi);
    end

    // Number of entries written this cycle, pointer and occupancy updates.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_mask[i]) begin
                push_n = push_n + CW'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + AW'(push_n);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + push_n - CW'(rd_en);
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_en && wr_mask[i]) begin
                mem[lane_addr[i]] <= wr_data[i];
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/difftest_commit_queue.sv
// Commit buffer between a multi-issue retire stage and the single-lane
// difftest commit/trap ports. Buffers up to IN_LANES commits per cycle,
// emits one registered commit per cycle, detects the trap instruction and
// keeps the cycle/instruction counters that freeze once the trap retires.
module difftest_commit_queue #(
    parameter  int         XLEN        = 64,
    parameter  int         IN_LANES    = 2,
    parameter  int         DEPTH       = 8,
    parameter  logic [6:0] TRAP_OPCODE = difftest_pkg::TRAP_OPCODE,
    localparam int         CW          = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [IN_LANES-1:0]      in_valid,
    output logic                     in_ready,
    input  logic [IN_LANES*XLEN-1:0] in_pc,
    input  logic [IN_LANES*32-1:0]   in_inst,
    input  logic [IN_LANES-1:0]      in_wen,
    input  logic [IN_LANES*5-1:0]    in_wdest,
    input  logic [IN_LANES*XLEN-1:0] in_wdata,
    input  logic [IN_LANES*XLEN-1:0] in_a0,
    output logic                     out_valid,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_wen,
    output logic [7:0]               out_wdest,
    output logic [XLEN-1:0]          out_wdata,
    output logic                     trap_valid,
    output logic [7:0]               trap_code,
    output logic [XLEN-1:0]          trap_pc,
    output logic [63:0]              cycle_cnt,
    output logic [63:0]              instr_cnt,
    output logic [CW-1:0]            count
);
    import difftest_pkg::*;

    commit_entry_t [IN_LANES-1:0] lane_entry;
    commit_entry_t                head;
    logic [CW-1:0]                fifo_count;
    logic [CW:0]                  free_slots;
    logic                         deq;

    logic            out_valid_q,  out_valid_d;
    logic [XLEN-1:0] out_pc_q,     out_pc_d;
    logic [31:0]     out_inst_q,   out_inst_d;
    logic            out_wen_q,    out_wen_d;
    logic [4:0]      out_wdest_q,  out_wdest_d;
    logic [XLEN-1:0] out_wdata_q,  out_wdata_d;
    logic            trap_seen_q,  trap_seen_d;
    logic [7:0]      trap_code_q,  trap_code_d;
    logic [XLEN-1:0] trap_pc_q,    trap_pc_d;
    logic [63:0]     cycle_cnt_q,  cycle_cnt_d;
    logic [63:0]     instr_cnt_q,  instr_cnt_d;

    // Unpack the flat per-lane buses into queue entries.
    for (genvar gi = 0; gi < IN_LANES; gi++) begin : g_lane
        assign lane_entry[gi] = '{
            pc:    64'(in_pc[gi*XLEN +: XLEN]),
            inst:  in_inst[gi*32 +: 32],
            wen:   in_wen[gi],
            wdest: in_wdest[gi*5 +: 5],
            wdata: 64'(in_wdata[gi*XLEN +: XLEN]),
            a0:    64'(in_a0[gi*XLEN +: XLEN])
        };
    end

    // Acceptance looks only at registered occupancy: a dequeue in the same
    // cycle does not open room early, which keeps in_ready off any long path.
    always_comb begin
        free_slots = (CW+1)'(DEPTH) - {1'b0, fifo_count};
        in_ready   = !trap_seen_q && (free_slots >= (CW+1)'(IN_LANES));
        deq        = (fifo_count != '0) && !trap_seen_q;
    end

    commit_fifo_mw #(
        .LANES (IN_LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (in_ready),
        .wr_mask (in_valid),
        .wr_data (lane_entry),
        .rd_en   (deq),
        .rd_data (head),
        .count   (fifo_count)
    );

    // Output stage, trap capture and counters; fields hold when idle.
    always_comb begin
        out_valid_d = deq;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        out_wen_d   = out_wen_q;
        out_wdest_d = out_wdest_q;
        out_wdata_d = out_wdata_q;
        trap_seen_d = trap_seen_q;
        trap_code_d = trap_code_q;
        trap_pc_d   = trap_pc_q;
        cycle_cnt_d = trap_seen_q ? cycle_cnt_q : cycle_cnt_q + 64'd1;
        instr_cnt_d = instr_cnt_q;
        if (deq) begin
            out_pc_d    = XLEN'(head.pc);
            out_inst_d  = head.inst;
            out_wen_d   = head.wen;
            out_wdest_d = head.wdest;
            out_wdata_d = XLEN'(head.wdata);
            instr_cnt_d = instr_cnt_q + 64'd1;
            if (is_trap_inst(head.inst, TRAP_OPCODE)) begin
                trap_seen_d = 1'b1;
                trap_code_d = head.a0[7:0];
                trap_pc_d   = XLEN'(head.pc);
            end
        end
    end

    // Registered outputs and sticky trap state.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_wen_q   <= 1'b0;
            out_wdest_q <= '0;
            out_wdata_q <= '0;
            trap_seen_q <= 1'b0;
            trap_code_q <= '0;
            trap_pc_q   <= '0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_wen_q   <= out_wen_d;
            out_wdest_q <= out_wdest_d;
            out_wdata_q <= out_wdata_d;
            trap_seen_q <= trap_seen_d;
            trap_code_q <= trap_code_d;
            trap_pc_q   <= trap_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // Producer contract: valid lanes are packed from lane 0 upward.
    always_ff @(posedge clock) begin
        if (!reset && in_ready) begin
            assert ((({1'b0, in_valid}) & (({1'b0, in_valid}) + 1'b1)) == '0);
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_inst   = out_inst_q;
    assign out_wen    = out_wen_q;
    assign out_wdest  = {3'b000, out_wdest_q};
    assign out_wdata  = out_wdata_q;
    assign trap_valid = trap_seen_q;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign instr_cnt  = instr_cnt_q;
    assign count      = fifo_count;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Randomised bench for difftest_commit_queue against a queue-based model.
module tb_difftest_commit_queue;

    localparam int XLEN  = 64;
    localparam int LANES = 2;
    localparam int DEPTH = 8;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [LANES-1:0]      in_valid;
    logic                  in_ready;
    logic [LANES*XLEN-1:0] in_pc, in_wdata, in_a0;
    logic [LANES*32-1:0]   in_inst;
    logic [LANES-1:0]      in_wen;
    logic [LANES*5-1:0]    in_wdest;
    logic                  out_valid, out_wen, trap_valid;
    logic [XLEN-1:0]       out_pc, out_wdata, trap_pc;
    logic [31:0]           out_inst;
    logic [7:0]            out_wdest, trap_code;
    logic [63:0]           cycle_cnt, instr_cnt;
    logic [3:0]            count;

    always #5 clock = ~clock;

    difftest_commit_queue #(.XLEN(XLEN), .IN_LANES(LANES), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_a0(in_a0), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_wen(out_wen), .out_wdest(out_wdest),
        .out_wdata(out_wdata), .trap_valid(trap_valid), .trap_code(trap_code),
        .trap_pc(trap_pc), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .count(count)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic [63:0] a0;
    } ent_t;

    // Behavioural model: a plain queue of retired instructions plus the
    // values the difftest ports should show after each clock edge.
    ent_t        lane_e [LANES];
    ent_t        mq [$];
    logic        m_trap;
    logic [7:0]  m_code;
    logic [63:0] m_tpc, m_cyc, m_icnt;
    logic        e_valid, e_wen;
    logic [63:0] e_pc, e_wdata;
    logic [31:0] e_inst;
    logic [4:0]  e_wdest;
    logic        last_acc;
    logic [63:0] pc_ctr;

    int errors = 0;
    int checks = 0;

    function automatic ent_t mk(input logic [63:0] pc, input bit trap, input logic [63:0] a0);
        ent_t e;
        logic [31:0] r;
        r = $urandom;
        if (trap) r[6:0] = 7'h6b;
        else if (r[6:0] == 7'h6b) r[6:0] = 7'h33;
        e.pc = pc; e.inst = r; e.wen = 1'($urandom_range(0, 1));
        e.wdest = 5'($urandom_range(0, 31)); e.wdata = {$urandom, $urandom}; e.a0 = a0;
        return e;
    endfunction

    function automatic bit model_ready();
        return !m_trap && ((DEPTH - mq.size()) >= LANES);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_trap = 0; m_code = 0; m_tpc = 0; m_cyc = 0; m_icnt = 0;
        e_valid = 0; e_wen = 0; e_pc = 0; e_wdata = 0; e_inst = 0; e_wdest = 0;
    endtask

    task automatic drive(input logic [LANES-1:0] mask);
        in_valid = mask;
        for (int i = 0; i < LANES; i++) begin
            in_pc[i*XLEN +: XLEN]    = lane_e[i].pc;
            in_inst[i*32 +: 32]      = lane_e[i].inst;
            in_wen[i]                = lane_e[i].wen;
            in_wdest[i*5 +: 5]       = lane_e[i].wdest;
            in_wdata[i*XLEN +: XLEN] = lane_e[i].wdata;
            in_a0[i*XLEN +: XLEN]    = lane_e[i].a0;
        end
    endtask

    // Fresh group of sequential, non-trap instructions.
    task automatic new_group();
        for (int i = 0; i < LANES; i++) begin
            lane_e[i] = mk(pc_ctr, 0, 64'($urandom));
            pc_ctr = pc_ctr + 64'd4;
        end
    endtask

    // Advance model and DUT by one clock edge with the currently driven inputs.
    task automatic tick();
        ent_t e;
        bit rdy, deq;
        rdy = model_ready();
        deq = (mq.size() > 0) && !m_trap;
        if (!m_trap) m_cyc = m_cyc + 1;
        e_valid = 0;
        if (deq) begin
            e = mq.pop_front();
            e_valid = 1; e_pc = e.pc; e_inst = e.inst; e_wen = e.wen;
            e_wdest = e.wdest; e_wdata = e.wdata;
            m_icnt = m_icnt + 1;
            if (e.inst[6:0] == 7'h6b) begin
                m_trap = 1; m_code = e.a0[7:0]; m_tpc = e.pc;
            end
        end
        if (rdy) for (int i = 0; i < LANES; i++) if (in_valid[i]) mq.push_back(lane_e[i]);
        last_acc = rdy;
        @(posedge clock);
        #1;
        if (out_valid)
            $display("commit pc=%h inst=%h wen=%0d wdest=%0d wdata=%h trap=%0d",
                     out_pc, out_inst, out_wen, out_wdest, out_wdata, trap_valid);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (cycle_cnt !== 64'd0) begin errors++; $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); end
        checks++; if (instr_cnt !== 64'd0) begin errors++; $display("FAIL reset_instr_cnt got %0d want 0", instr_cnt); end
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL reset_trap_valid got %0d want 0", trap_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d want 1", in_ready); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
    endtask

    task automatic test_single_lane();
        do_reset();
        lane_e[0] = '{pc: 64'h8000_0000, inst: 32'h0010_0093, wen: 1'b1, wdest: 5'd1, wdata: 64'd1, a0: 64'd0};
        lane_e[1] = mk(64'h8000_0004, 0, 64'd0);
        drive(2'b01);
        tick();
        drive(2'b00);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0d want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0d want 1", out_valid); end
        checks++; if (out_wdest !== 8'd1) begin errors++; $display("FAIL single_wdest got %0d want 1", out_wdest); end
        checks++; if (out_pc !== 64'h8000_0000) begin errors++; $display("FAIL single_pc got %h want 80000000", out_pc); end
        checks++; if (out_inst !== 32'h0010_0093) begin errors++; $display("FAIL single_inst got %h want 00100093", out_inst); end
        checks++; if (instr_cnt !== 64'd1) begin errors++; $display("FAIL single_instr_cnt got %0d want 1", instr_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_end got %0d want 0", out_valid); end
        checks++; if (out_wdata !== 64'd1) begin errors++; $display("FAIL single_hold_wdata got %h want 1", out_wdata); end
    endtask

    task automatic test_back_to_back();
        int g = 0, emitted = 0;
        logic [63:0] nxt;
        do_reset();
        pc_ctr = 64'h8000_0000; nxt = pc_ctr;
        new_group();
        for (int cyc = 0; cyc < 200 && emitted < 16; cyc++) begin
            drive(g < 8 ? 2'b11 : 2'b00);
            checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL b2b_ready got %0d want %0d", in_ready, model_ready()); end
            if (mq.size() >= 7) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %0d want 0 at occupancy %0d", in_ready, mq.size()); end
            end
            tick();
            if (last_acc && g < 8) begin g++; if (g < 8) new_group(); end
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL b2b_valid got %0d want %0d", out_valid, e_valid); end
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL b2b_count got %0d want %0d", count, mq.size()); end
            if (out_valid) begin
                checks++; if (out_pc !== nxt) begin errors++; $display("FAIL b2b_order got %h want %h", out_pc, nxt); end
                checks++; if (out_wdata !== e_wdata || out_inst !== e_inst) begin errors++; $display("FAIL b2b_data got %h/%h want %h/%h", out_wdata, out_inst, e_wdata, e_inst); end
                nxt = nxt + 64'd4; emitted++;
            end
        end
        checks++; if (emitted != 16) begin errors++; $display("FAIL b2b_emitted got %0d want 16", emitted); end
        checks++; if (instr_cnt !== 64'd16) begin errors++; $display("FAIL b2b_instr_cnt got %0d want 16", instr_cnt); end
    endtask

    task automatic test_wrap();
        int g = 0, sent = 0, emitted = 0;
        bit pending = 0;
        logic [LANES-1:0] mask = '0;
        logic [63:0] nxt;
        do_reset();
        pc_ctr = 64'h8000_1000; nxt = pc_ctr;
        for (int cyc = 0; cyc < 600 && (g < 20 || emitted < sent); cyc++) begin
            if (!pending && g < 20 && $urandom_range(0, 3) != 0) begin
                mask = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
                lane_e[0] = mk(pc_ctr, 0, 64'($urandom));
                lane_e[1] = mk(pc_ctr + 64'd4, 0, 64'($urandom));
                pc_ctr = pc_ctr + (mask == 2'b11 ? 64'd8 : 64'd4);
                pending = 1;
            end
            drive(pending ? mask : 2'b00);
            checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL wrap_ready got %0d want %0d", in_ready, model_ready()); end
            tick();
            if (pending && last_acc) begin pending = 0; g++; sent += (mask == 2'b11) ? 2 : 1; end
            checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL wrap_valid got %0d want %0d", out_valid, e_valid); end
            if (out_valid) begin
                checks++; if (out_pc !== nxt) begin errors++; $display("FAIL wrap_order got %h want %h", out_pc, nxt); end
                checks++; if (out_wen !== e_wen || out_wdest !== {3'b0, e_wdest} || out_wdata !== e_wdata) begin
                    errors++; $display("FAIL wrap_fields got %0d/%0d/%h want %0d/%0d/%h", out_wen, out_wdest, out_wdata, e_wen, e_wdest, e_wdata); end
                nxt = nxt + 64'd4; emitted++;
            end
        end
        checks++; if (emitted != sent || g != 20) begin errors++; $display("FAIL wrap_total got %0d of %0d groups %0d want all of 20", emitted, sent, g); end
        checks++; if (instr_cnt !== m_icnt) begin errors++; $display("FAIL wrap_instr_cnt got %0d want %0d", instr_cnt, m_icnt); end
        checks++; if (cycle_cnt !== m_cyc) begin errors++; $display("FAIL wrap_cycle_cnt got %0d want %0d", cycle_cnt, m_cyc); end
    endtask

    task automatic test_trap_lane1();
        logic [63:0] base = 64'h8000_2000;
        do_reset();
        lane_e[0] = mk(base, 0, 64'd5);
        lane_e[1] = mk(base + 64'd4, 1, 64'd0);
        drive(2'b11); tick();
        lane_e[0] = mk(base + 64'd8, 0, 64'd1);
        lane_e[1] = mk(base + 64'd12, 0, 64'd2);
        drive(2'b11); tick();
        checks++; if (trap_valid !== 1'b0) begin errors++; $display("FAIL trap_early got %0d want 0", trap_valid); end
        drive(2'b00); tick();
        checks++; if (out_valid !== 1'b1 || trap_valid !== 1'b1) begin errors++; $display("FAIL trap_same_cycle got valid=%0d trap=%0d want 1/1", out_valid, trap_valid); end
        checks++; if (trap_code !== 8'd0) begin errors++; $display("FAIL trap_code got %h want 00", trap_code); end
        checks++; if (trap_pc !== base + 64'd4) begin errors++; $display("FAIL trap_pc got %h want %h", trap_pc, base + 64'd4); end
        checks++; if (instr_cnt !== 64'd2) begin errors++; $display("FAIL trap_instr_cnt got %0d want 2", instr_cnt); end
        new_group();
        for (int k = 0; k < 6; k++) begin
            drive(2'b11); tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL trap_after_valid got %0d want 0", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL trap_after_ready got %0d want 0", in_ready); end
            checks++; if (cycle_cnt !== m_cyc || instr_cnt !== 64'd2) begin errors++; $display("FAIL trap_frozen got %0d/%0d want %0d/2", cycle_cnt, instr_cnt, m_cyc); end
            checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL trap_sticky got %0d want 1", trap_valid); end
        end
    endtask

    task automatic test_trap_code_ff();
        do_reset();
        lane_e[0] = mk(64'h8000_3000, 1, 64'h1FF);
        lane_e[1] = mk(64'h8000_3004, 0, 64'd0);
        drive(2'b01); tick();
        drive(2'b00); tick();
        checks++; if (trap_valid !== 1'b1) begin errors++; $display("FAIL trapff_valid got %0d want 1", trap_valid); end
        checks++; if (trap_code !== 8'hFF) begin errors++; $display("FAIL trapff_code got %h want ff", trap_code); end
        checks++; if (trap_pc !== 64'h8000_3000) begin errors++; $display("FAIL trapff_pc got %h want 80003000", trap_pc); end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        pc_ctr = 64'h8000_4000;
        for (int k = 0; k < 4; k++) begin new_group(); drive(2'b11); tick(); end
        checks++; if (count !== 4'(mq.size()) || mq.size() != 5) begin errors++; $display("FAIL midburst_fill got %0d want 5 (model %0d)", count, mq.size()); end
        new_group();
        reset = 1'b1;
        drive(2'b11);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(2'b00);
        model_clear();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midburst_count got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midburst_valid got %0d want 0", out_valid); end
        checks++; if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin errors++; $display("FAIL midburst_counters got %0d/%0d want 0/0", cycle_cnt, instr_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midburst_ready got %0d want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || cycle_cnt !== 64'd1) begin errors++; $display("FAIL midburst_drained got valid=%0d cyc=%0d want 0/1", out_valid, cycle_cnt); end
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) lane_e[i] = mk(64'h0, 0, 64'h0);
        pc_ctr = 64'h8000_0000;
        model_clear();
        drive('0);
        test_reset();
        test_single_lane();
        test_back_to_back();
        test_wrap();
        test_trap_lane1();
        test_trap_code_ff();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
